if_fetch_unit: RTL

- Instruction-fetch stage directly upstream of the ID stage.
- Holds the PC, issues one-outstanding-request fetches to instruction memory, and drives the IF/ID output register.
- Applies taken-branch redirects from ID's branch_flag/branch_addr with MIPS one-instruction delay-slot semantics.
- Handles pipeline stall and exception flush, including flush while a memory request is in flight.

---
 rtl/if_fetch_unit.sv | 161 ++++++++++++++++
 1 files changed

// File: rtl/if_fetch_unit.sv
// rtl/if_fetch_unit.sv - instruction-fetch stage with delay-slot redirect, stall and flush
//
// Holds the PC, runs single-outstanding fetches to instruction memory and
// drives the IF/ID register.
//
// Ports:
//   i_clk, i_rst_n             clock; synchronous active-low reset
//   i_stall                    hold IF/ID outputs, ID consumes nothing
//   i_flush, i_flush_pc        exception/eret redirect, highest priority
//   i_branch_flag, i_branch_addr  taken branch/jump of the instruction in ID
//   o_imem_req, o_imem_addr    fetch request, held high until ack
//   i_imem_ack, i_imem_rdata   one-cycle response, may coincide with request rise
//   o_if_valid, o_if_pc, o_if_inst  IF/ID register
module if_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                INST_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = 32'hBFC0_0000
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic              i_stall,
  input  logic              i_flush,
  input  logic [ADDR_W-1:0] i_flush_pc,
  input  logic              i_branch_flag,
  input  logic [ADDR_W-1:0] i_branch_addr,
  output logic              o_imem_req,
  output logic [ADDR_W-1:0] o_imem_addr,
  input  logic              i_imem_ack,
  input  logic [INST_W-1:0] i_imem_rdata,
  output logic              o_if_valid,
  output logic [ADDR_W-1:0] o_if_pc,
  output logic [INST_W-1:0] o_if_inst
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_HOLD, S_DISCARD} state_t;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(3);
  localparam logic [ADDR_W-1:0] INSN_BYTES = ADDR_W'(4);

  state_t            r_state;
  logic [ADDR_W-1:0] r_pc;
  logic [ADDR_W-1:0] r_imem_addr;
  logic              r_imem_req;
  logic [ADDR_W-1:0] r_hold_pc;
  logic [INST_W-1:0] r_hold_inst;
  logic              r_if_valid;
  logic [ADDR_W-1:0] r_if_pc;
  logic [INST_W-1:0] r_if_inst;

  logic              w_take_branch;
  logic [ADDR_W-1:0] w_branch_addr;
  logic [ADDR_W-1:0] w_flush_pc;
  logic [ADDR_W-1:0] w_nfa;
  logic              w_issue;
  logic [ADDR_W-1:0] w_issue_addr;

  // A branch only counts on the cycle ID actually consumes it.
  assign w_take_branch = i_branch_flag & ~i_stall & ~i_flush;
  assign w_branch_addr = i_branch_addr & ALIGN_MASK;
  assign w_flush_pc    = i_flush_pc & ALIGN_MASK;
  assign w_nfa         = w_take_branch ? w_branch_addr : r_pc;

  // Decide whether a new fetch is launched this cycle and from where.
  always_comb begin
    w_issue      = 1'b0;
    w_issue_addr = w_nfa;
    if (i_flush) begin
      w_issue_addr = w_flush_pc;
      case (r_state)
        S_REQ:     w_issue = i_imem_ack;
        S_DISCARD: w_issue = 1'b0;
        default:   w_issue = 1'b1;
      endcase
    end else begin
      case (r_state)
        S_IDLE:  w_issue = 1'b1;
        S_REQ:   w_issue = i_imem_ack & ~i_stall;
        S_HOLD:  w_issue = ~i_stall;
        default: begin
          // The flush target already sits in r_pc; the stale ack just frees the bus.
          w_issue      = i_imem_ack;
          w_issue_addr = r_pc;
        end
      endcase
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_pc        <= RESET_PC;
      r_imem_addr <= '0;
      r_imem_req  <= 1'b0;
      r_hold_pc   <= '0;
      r_hold_inst <= '0;
      r_if_valid  <= 1'b0;
      r_if_pc     <= '0;
      r_if_inst   <= '0;
    end else begin
      if (w_issue) begin
        r_imem_addr <= w_issue_addr;
        r_pc        <= w_issue_addr + INSN_BYTES;
        r_imem_req  <= 1'b1;
      end else if (i_flush) begin
        r_pc <= w_flush_pc;
      end else if (w_take_branch) begin
        // Delay-slot fetch is still in flight; retarget the one after it.
        r_pc <= w_branch_addr;
      end

      if (i_flush) begin
        r_if_valid <= 1'b0;
        if (r_state == S_REQ && !i_imem_ack) begin
          r_state <= S_DISCARD;
        end else if (r_state != S_DISCARD) begin
          r_state <= S_REQ;
        end
      end else begin
        case (r_state)
          S_IDLE: r_state <= S_REQ;
          S_REQ: begin
            if (i_imem_ack) begin
              if (!i_stall) begin
                r_if_valid <= 1'b1;
                r_if_pc    <= r_imem_addr;
                r_if_inst  <= i_imem_rdata;
              end else begin
                r_hold_pc   <= r_imem_addr;
                r_hold_inst <= i_imem_rdata;
                r_imem_req  <= 1'b0;
                r_state     <= S_HOLD;
              end
            end else if (!i_stall) begin
              r_if_valid <= 1'b0;
            end
          end
          S_HOLD: begin
            if (!i_stall) begin
              r_if_valid <= 1'b1;
              r_if_pc    <= r_hold_pc;
              r_if_inst  <= r_hold_inst;
              r_state    <= S_REQ;
            end
          end
          default: begin
            if (i_imem_ack) begin
              r_state <= S_REQ;
            end
          end
        endcase
      end
    end
  end

  assign o_imem_req  = r_imem_req;
  assign o_imem_addr = r_imem_addr;
  assign o_if_valid  = r_if_valid;
  assign o_if_pc     = r_if_pc;
  assign o_if_inst   = r_if_inst;

endmodule
